pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage Y86-64 core. Each cycle it drives the stall and bubble controls for the F/D/E/M/W pipeline registers. It detects load-use and `ret` hazards and branch mispredicts, freezes the pipeline while the data memory is not ready (with a timeout), and latches a halted state when a non-AOK status retires. It sits beside the decode and execute stages and takes their icode, register-ID and status fields.

## Interface
Parameters:
- TIMEOUT, 16: max consecutive memory-wait cycles before forced release (≥2)
- CNT_W, 32: width of performance counters

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- D_icode_i  in  4  icode in decode register
- E_icode_i  in  4  icode in execute register
- M_icode_i  in  4  icode in memory register
- E_dstM_i  in  4  dstM of instruction in execute
- d_srcA_i  in  4  srcA produced by decode
- d_srcB_i  in  4  srcB produced by decode
- e_Cnd_i  in  1  condition result from execute
- m_stat_i  in  4  status leaving memory stage
- W_stat_i  in  4  status in writeback register
- dmem_req_i  in  1  memory stage is accessing data memory this cycle
- dmem_ready_i  in  1  data memory completes access this cycle
- F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o  out  1 each  hold pipeline register
- D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o  out  1 each  load nop into pipeline register
- halted_o  out  1  core halted (sticky until reset)
- mem_timeout_o  out  1  one-cycle pulse: memory wait forcibly released
- cycle_cnt_o  out  CNT_W  cycles since reset while not halted
- stall_cnt_o  out  CNT_W  cycles with F_stall_o asserted while not halted

## Operation
- Encodings: RNONE=4'hF, IMRMOVQ=4'h5, IJXX=4'h7, IRET=4'h9, IPOPQ=4'hB, SAOK=4'h1.
- Terms:
  - load_use = E_icode∈{IMRMOVQ,IPOPQ} & E_dstM≠RNONE & (E_dstM==d_srcA | E_dstM==d_srcB)
  - ret_p = IRET ∈ {D,E,M}_icode
  - mispred = E_icode==IJXX & !e_Cnd
  - exc_m = m_stat≠SAOK
  - exc_w = W_stat≠SAOK
  - mem_wait = dmem_req & !dmem_ready & !force_rel
- States: RUN, MEMWAIT, HALT.
- RUN, no mem_wait:
  - F_stall = load_use|ret_p
  - D_stall = load_use
  - D_bubble = mispred | (ret_p & !load_use)
  - E_bubble = mispred|load_use
  - M_bubble = exc_m|exc_w
  - W_stall = exc_w
  - E_stall, M_stall and W_bubble are 0.
- mem_wait (RUN or MEMWAIT): F/D/E/M_stall=1 and all other bubbles=0.
  - W_bubble=1 unless exc_w; if exc_w, W_stall=1 and W_bubble=0.
- Transitions:
  - RUN→MEMWAIT when mem_wait.
  - MEMWAIT→RUN when dmem_ready or forced release.
  - Any state→HALT when exc_w (checked first).
  - HALT→RUN only via rst_i.
- Wait counter: cleared in RUN, incremented each MEMWAIT cycle.
  - When it equals TIMEOUT-1 with ready low, force_rel is asserted on the next cycle.
  - On that cycle the freeze drops, mem_timeout_o pulses, and the state returns to RUN.
  - The memory stage converts the access to SADR.
- HALT: all *_stall=1, all bubbles=0, halted_o=1, counters frozen.
- Never assert stall and bubble for the same register in the same cycle.

## Timing
- Stall/bubble outputs are combinational from inputs and current state, valid in the same cycle.
- halted_o and mem_timeout_o are registered.
- halted_o rises the cycle after exc_w is first seen.
- Reset (rst_i high at edge): state=RUN, wait_cnt=0, halted_o=0, mem_timeout_o=0, counters=0.
- While rst_i is high: all stalls=0 and all bubbles=1, so the pipe flushes to nops. This holds regardless of other inputs, including reset mid-MEMWAIT or in HALT.
- Counters wrap modulo 2^CNT_W. Neither counter increments on a cycle where rst_i is high.
- Simultaneous events:
  - exc_w beats mem_wait.
  - mem_wait beats load_use/ret/mispred.
  - load_use beats ret_p for D (stall, not bubble).
- dmem_ready high in the first request cycle: no freeze, and the state stays RUN.
- Minimum forced-release latency: TIMEOUT cycles of freeze followed by one release cycle.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcB=3, others nop → F_stall=D_stall=E_bubble=1, D_bubble=0; next cycle with E_icode=1 → all 0.
- Ret: D_icode=9 held three cycles in D/E/M successively → F_stall=1 and D_bubble=1 each cycle; combined with load_use on the E_icode=B cycle → D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0.
- Memory wait: dmem_req=1, ready low 3 cycles then high → F/D/E/M_stall=1 and W_bubble=1 for 3 cycles, released in the 4th; stall_cnt increments by 3.
- Timeout (TIMEOUT=4): ready never rises → 4 frozen cycles, then mem_timeout_o=1 for one cycle and the stalls drop.
- Halt: W_stat=2 → W_stall=M_bubble=1 that cycle; halted_o=1 next cycle, all stalls=1, counters frozen; rst_i for one cycle → halted_o=0, counters=0, bubbles=1 during reset.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 five-stage pipeline stall/bubble sequencing controller
module pipe_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       m_stat_i,
    input  logic [3:0]       W_stat_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic             halted_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] SAOK    = 4'h1;

    localparam int WC_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] wait_cnt;
    logic            force_rel;
    logic            halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic load_use;
    logic ret_p;
    logic mispred;
    logic exc_m;
    logic exc_w;
    logic mem_wait;
    logic wait_last;

    assign load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                      (E_dstM_i != RNONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign ret_p    = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
    assign exc_m    = (m_stat_i != SAOK);
    assign exc_w    = (W_stat_i != SAOK);
    // force_rel masks the request for exactly one cycle so the memory stage can retire it as SADR
    assign mem_wait = dmem_req_i && !dmem_ready_i && !force_rel;
    // wait_cnt counts every frozen cycle, so reaching TIMEOUT-1 means TIMEOUT cycles of freeze
    assign wait_last = (wait_cnt == WC_W'(TIMEOUT - 1));

    // Next-state and per-register stall/bubble decode; reset flushes the pipe with nops
    always_comb begin
        state_next = state;
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        W_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_bubble_o = 1'b0;
        if (rst_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_bubble_o = 1'b1;
        end else begin
            case (state)
                HALT: begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    M_stall_o = 1'b1;
                    W_stall_o = 1'b1;
                end
                default: begin
                    if (mem_wait) begin
                        F_stall_o  = 1'b1;
                        D_stall_o  = 1'b1;
                        E_stall_o  = 1'b1;
                        M_stall_o  = 1'b1;
                        W_stall_o  = exc_w;
                        W_bubble_o = !exc_w;
                    end else begin
                        F_stall_o  = load_use || ret_p;
                        D_stall_o  = load_use;
                        D_bubble_o = mispred || (ret_p && !load_use);
                        E_bubble_o = mispred || load_use;
                        M_bubble_o = exc_m || exc_w;
                        W_stall_o  = exc_w;
                    end
                    if (exc_w) begin
                        state_next = HALT;
                    end else if (mem_wait) begin
                        state_next = MEMWAIT;
                    end else begin
                        state_next = RUN;
                    end
                end
            endcase
        end
    end

    // State register, wait timer, registered status flags and performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            force_rel <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            halted    <= (state_next == HALT);
            force_rel <= (state == MEMWAIT) && mem_wait && !exc_w && wait_last;
            if (mem_wait && (state != HALT)) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (F_stall_o) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign halted_o      = halted;
    assign mem_timeout_o = force_rel;
    assign cycle_cnt_o   = cycle_cnt;
    assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed vectors
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [3:0]       D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic             e_Cnd;
    logic [3:0]       m_stat, W_stat;
    logic             dmem_req, dmem_ready;
    logic             F_stall, D_stall, E_stall, M_stall, W_stall;
    logic             D_bubble, E_bubble, M_bubble, W_bubble;
    logic             halted, mem_timeout;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt;

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .E_icode_i(E_icode), .M_icode_i(M_icode),
        .E_dstM_i(E_dstM), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .e_Cnd_i(e_Cnd), .m_stat_i(m_stat), .W_stat_i(W_stat),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .E_stall_o(E_stall),
        .M_stall_o(M_stall), .W_stall_o(W_stall),
        .D_bubble_o(D_bubble), .E_bubble_o(E_bubble),
        .M_bubble_o(M_bubble), .W_bubble_o(W_bubble),
        .halted_o(halted), .mem_timeout_o(mem_timeout),
        .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [8:0]       ctrl;   // {F,D,E,M,W stall, D,E,M,W bubble}
        logic             hlt;
        logic             tmo;
        logic             chk_cnt;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] stl;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               vec_idx = 0;
    logic [CNT_W-1:0] m_cyc = '0;
    logic [CNT_W-1:0] m_stl = '0;

    task automatic idle();
        rst        = 1'b0;
        D_icode    = 4'h1;
        E_icode    = 4'h1;
        M_icode    = 4'h1;
        E_dstM     = 4'hF;
        d_srcA     = 4'hF;
        d_srcB     = 4'hF;
        e_Cnd      = 1'b1;
        m_stat     = 4'h1;
        W_stat     = 4'h1;
        dmem_req   = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // Pushes the expected response for the inputs currently driven, then advances one cycle
    task automatic expect_vec(input logic [8:0] ctrl, input logic hlt, input logic tmo,
                              input logic chk_cnt);
        exp_t e;
        e.idx     = vec_idx;
        e.ctrl    = ctrl;
        e.hlt     = hlt;
        e.tmo     = tmo;
        e.chk_cnt = chk_cnt;
        e.cyc     = m_cyc;
        e.stl     = m_stl;
        sb.push_back(e);
        if (rst) begin
            m_cyc = '0;
            m_stl = '0;
        end else if (!hlt) begin
            m_cyc = m_cyc + 1;
            if (ctrl[8]) m_stl = m_stl + 1;
        end
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares it against the DUT outputs
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {F_stall, D_stall, E_stall, M_stall, W_stall,
                   D_bubble, E_bubble, M_bubble, W_bubble};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl vec %0d: got %b want %b", e.idx, act, e.ctrl);
            end
            checks++;
            if (halted !== e.hlt) begin
                errors++;
                $display("FAIL halted vec %0d: got %b want %b", e.idx, halted, e.hlt);
            end
            checks++;
            if (mem_timeout !== e.tmo) begin
                errors++;
                $display("FAIL mem_timeout vec %0d: got %b want %b", e.idx, mem_timeout, e.tmo);
            end
            if (e.chk_cnt) begin
                checks++;
                if (cycle_cnt !== e.cyc) begin
                    errors++;
                    $display("FAIL cycle_cnt vec %0d: got %0d want %0d", e.idx, cycle_cnt, e.cyc);
                end
                checks++;
                if (stall_cnt !== e.stl) begin
                    errors++;
                    $display("FAIL stall_cnt vec %0d: got %0d want %0d", e.idx, stall_cnt, e.stl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // reset with hostile inputs: flush to nops
        idle(); rst = 1'b1; W_stat = 4'h2; dmem_req = 1'b1;
        expect_vec(9'b00000_1111, 1'b0, 1'b0, 1'b1);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // load-use then clear
        idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        expect_vec(9'b11000_0100, 1'b0, 1'b0, 1'b0);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b0);
        // ret moving through D, E, M
        idle(); D_icode = 4'h9;
        expect_vec(9'b10000_1000, 1'b0, 1'b0, 1'b0);
        idle(); E_icode = 4'h9;
        expect_vec(9'b10000_1000, 1'b0, 1'b0, 1'b0);
        idle(); M_icode = 4'h9;
        expect_vec(9'b10000_1000, 1'b0, 1'b0, 1'b0);
        // ret in D with popq load-use in E: stall D, no bubble
        idle(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h3; d_srcA = 4'h3;
        expect_vec(9'b11000_0100, 1'b0, 1'b0, 1'b0);
        // load with dstM=RNONE is not a hazard
        idle(); E_icode = 4'h5; E_dstM = 4'hF;
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b0);
        // mispredict, then taken jump
        idle(); E_icode = 4'h7; e_Cnd = 1'b0;
        expect_vec(9'b00000_1100, 1'b0, 1'b0, 1'b0);
        idle(); E_icode = 4'h7; e_Cnd = 1'b1;
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // memory wait 3 cycles, load-use masked by the freeze, release on ready
        idle(); dmem_req = 1'b1;
        expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        idle(); dmem_req = 1'b1; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        idle(); dmem_req = 1'b1;
        expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // ready in the first request cycle: no freeze
        idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b0);
        // timeout: 4 frozen cycles then one release cycle with pulse
        for (int i = 0; i < 4; i++) begin
            idle(); dmem_req = 1'b1;
            expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        end
        idle(); dmem_req = 1'b1;
        expect_vec(9'b00000_0000, 1'b0, 1'b1, 1'b1);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // memory-stage exception bubbles M
        idle(); m_stat = 4'h3;
        expect_vec(9'b00000_0010, 1'b0, 1'b0, 1'b0);
        // halt: exception retires, then sticky halt with counters frozen
        idle(); W_stat = 4'h2;
        expect_vec(9'b00001_0010, 1'b0, 1'b0, 1'b1);
        idle();
        expect_vec(9'b11111_0000, 1'b1, 1'b0, 1'b1);
        idle(); dmem_req = 1'b1; E_icode = 4'h7; e_Cnd = 1'b0;
        expect_vec(9'b11111_0000, 1'b1, 1'b0, 1'b1);
        idle(); rst = 1'b1;
        expect_vec(9'b00000_1111, 1'b1, 1'b0, 1'b1);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // reset in the middle of a memory wait
        idle(); dmem_req = 1'b1;
        expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        idle(); dmem_req = 1'b1;
        expect_vec(9'b11110_0001, 1'b0, 1'b0, 1'b0);
        idle(); rst = 1'b1; dmem_req = 1'b1;
        expect_vec(9'b00000_1111, 1'b0, 1'b0, 1'b1);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);
        // exception retiring during a memory wait: W held, then halt
        idle(); dmem_req = 1'b1; W_stat = 4'h3;
        expect_vec(9'b11111_0000, 1'b0, 1'b0, 1'b0);
        idle(); dmem_req = 1'b1;
        expect_vec(9'b11111_0000, 1'b1, 1'b0, 1'b1);
        idle(); rst = 1'b1;
        expect_vec(9'b00000_1111, 1'b1, 1'b0, 1'b1);
        idle();
        expect_vec(9'b00000_0000, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
